// File: rtl/vt52_pkg.sv
// Shared constants, control codes and FSM state encoding for the vt52-style
// character display write path.
package vt52_pkg;

  localparam int COLUMNS   = 80;
  localparam int ROWS      = 25;
  localparam int ROW_BITS  = 5;
  localparam int COL_BITS  = 7;
  localparam int ADDR_BITS = 11;
  localparam int CNT_BITS  = ADDR_BITS + 1;

  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [2:0] {
    ST_FILL_PTR = 3'd0,
    ST_FILL     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SCROLL   = 3'd4,
    ST_CLEAR    = 3'd5
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/screen_writer.sv
// Write-side controller for the 80x25 character display: places printable
// bytes at the cursor, handles CR/LF/BS/FF, scrolls and blanks the buffer.
module screen_writer
  import vt52_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic [7:0]           char_in,
  input  logic                 char_valid,
  output logic                 char_ready,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen
);

  localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLUMNS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [ADDR_BITS-1:0] ROW_STEP  = ADDR_BITS'(COLUMNS);
  localparam logic [CNT_BITS-1:0]  FILL_END  = CNT_BITS'(1 << ADDR_BITS);
  localparam logic [CNT_BITS-1:0]  CLEAR_END = CNT_BITS'(COLUMNS);

  state_t               state_r, state_s;
  logic [ADDR_BITS-1:0] first_char_r, first_char_s;
  logic [ADDR_BITS-1:0] row_addr_r, row_addr_s;
  logic [CNT_BITS-1:0]  cnt_r, cnt_s;
  logic [7:0]           char_r, char_s;
  logic [ROW_BITS-1:0]  row_s;
  logic [COL_BITS-1:0]  col_s;
  logic [ADDR_BITS-1:0] waddr_s, fc_s;
  logic [7:0]           din_s;
  logic                 wen_s, fc_wen_s, newline_s;

  assign char_ready = (state_r == ST_IDLE);

  // Next-state, cursor and registered-strobe decode.
  // Strobes are computed one cycle early so they appear in the cycle of the
  // state they belong to; the FILL pointer strobe lands in the first FILL cycle.
  always_comb begin
    state_s      = state_r;
    first_char_s = first_char_r;
    row_addr_s   = row_addr_r;
    cnt_s        = cnt_r;
    char_s       = char_r;
    row_s        = cursor_row;
    col_s        = cursor_col;
    waddr_s      = buffer_waddr;
    din_s        = buffer_din;
    wen_s        = 1'b0;
    fc_s         = buffer_first_char;
    fc_wen_s     = 1'b0;
    newline_s    = 1'b0;
    case (state_r)
      ST_FILL_PTR: begin
        fc_s     = {ADDR_BITS{1'b0}};
        fc_wen_s = 1'b1;
        cnt_s    = {CNT_BITS{1'b0}};
        state_s  = ST_FILL;
      end
      ST_FILL: begin
        if (cnt_r < FILL_END) begin
          waddr_s = cnt_r[ADDR_BITS-1:0];
          din_s   = CH_SPACE;
          wen_s   = 1'b1;
          cnt_s   = cnt_r + CNT_BITS'(1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (char_valid) begin
          char_s  = char_in;
          state_s = ST_EXEC;
          if (is_printable(char_in)) begin
            waddr_s = row_addr_r + ADDR_BITS'(cursor_col);
            din_s   = char_in;
            wen_s   = 1'b1;
          end else begin
            wen_s   = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_s = ST_IDLE;
        if (is_printable(char_r)) begin
          if (cursor_col < LAST_COL) begin
            col_s = cursor_col + COL_BITS'(1);
          end else begin
            col_s     = {COL_BITS{1'b0}};
            newline_s = 1'b1;
          end
        end else if (char_r == CH_CR) begin
          col_s = {COL_BITS{1'b0}};
        end else if (char_r == CH_LF) begin
          newline_s = 1'b1;
        end else if (char_r == CH_BS) begin
          if (cursor_col != {COL_BITS{1'b0}}) begin
            col_s = cursor_col - COL_BITS'(1);
          end else begin
            col_s = cursor_col;
          end
        end else if (char_r == CH_FF) begin
          row_s        = {ROW_BITS{1'b0}};
          col_s        = {COL_BITS{1'b0}};
          row_addr_s   = {ADDR_BITS{1'b0}};
          first_char_s = {ADDR_BITS{1'b0}};
          state_s      = ST_FILL_PTR;
        end else begin
          state_s = ST_IDLE;
        end
        if (newline_s) begin
          if (cursor_row < LAST_ROW) begin
            row_s      = cursor_row + ROW_BITS'(1);
            row_addr_s = row_addr_r + ROW_STEP;
          end else begin
            first_char_s = first_char_r + ROW_STEP;
            row_addr_s   = row_addr_r + ROW_STEP;
            fc_s         = first_char_r + ROW_STEP;
            fc_wen_s     = 1'b1;
            state_s      = ST_SCROLL;
          end
        end else begin
          row_addr_s = row_addr_s;
        end
      end
      ST_SCROLL: begin
        waddr_s = row_addr_r;
        din_s   = CH_SPACE;
        wen_s   = 1'b1;
        cnt_s   = CNT_BITS'(1);
        state_s = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt_r < CLEAR_END) begin
          waddr_s = row_addr_r + cnt_r[ADDR_BITS-1:0];
          din_s   = CH_SPACE;
          wen_s   = 1'b1;
          cnt_s   = cnt_r + CNT_BITS'(1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_FILL_PTR;
      end
    endcase
  end

  // State, cursor, pointer mirror and registered buffer outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r               <= ST_FILL_PTR;
      first_char_r          <= {ADDR_BITS{1'b0}};
      row_addr_r            <= {ADDR_BITS{1'b0}};
      cnt_r                 <= {CNT_BITS{1'b0}};
      char_r                <= 8'h00;
      cursor_row            <= {ROW_BITS{1'b0}};
      cursor_col            <= {COL_BITS{1'b0}};
      buffer_waddr          <= {ADDR_BITS{1'b0}};
      buffer_din            <= 8'h00;
      buffer_wen            <= 1'b0;
      buffer_first_char     <= {ADDR_BITS{1'b0}};
      buffer_first_char_wen <= 1'b0;
    end else begin
      state_r               <= state_s;
      first_char_r          <= first_char_s;
      row_addr_r            <= row_addr_s;
      cnt_r                 <= cnt_s;
      char_r                <= char_s;
      cursor_row            <= row_s;
      cursor_col            <= col_s;
      buffer_waddr          <= waddr_s;
      buffer_din            <= din_s;
      buffer_wen            <= wen_s;
      buffer_first_char     <= fc_s;
      buffer_first_char_wen <= fc_wen_s;
    end
  end

endmodule

// File: tb/tb_screen_writer.sv
// Scoreboard bench for screen_writer: expected buffer writes and pointer loads
// are queued at stimulus time and popped by an independent output monitor.
module tb_screen_writer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [10:0] buffer_waddr;
  logic [7:0]  buffer_din;
  logic        buffer_wen;
  logic [10:0] buffer_first_char;
  logic        buffer_first_char_wen;

  screen_writer dut (
    .clk(clk), .clr(clr), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .buffer_waddr(buffer_waddr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
    .buffer_first_char(buffer_first_char),
    .buffer_first_char_wen(buffer_first_char_wen)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_wr[$];
  int  exp_fc[$];
  int  n_vec  = 0;
  int  n_miss = 0;
  int  last_fc = -1;
  int  m_row = 0, m_col = 0, m_first = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got %0d, expected none", name, act);
  endtask

  // Output monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (buffer_wen && buffer_first_char_wen) flag("both_strobes", 1);
    if (buffer_wen) begin
      if (exp_wr.size() == 0) flag("unexpected_write", int'(buffer_waddr));
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("write_addr", 32'(buffer_waddr), e.addr);
        check("write_data", 32'(buffer_din), e.data);
      end
    end
    if (buffer_first_char_wen) begin
      last_fc = int'(buffer_first_char);
      if (exp_fc.size() == 0) flag("unexpected_first_char", last_fc);
      else check("first_char", 32'(buffer_first_char), exp_fc.pop_front());
    end
  end

  task automatic push_fill();
    wr_t w;
    exp_fc.push_back(0);
    for (int a = 0; a < 2048; a++) begin
      w.addr = a; w.data = 32;
      exp_wr.push_back(w);
    end
  endtask

  // Reference model: cursor/pointer tracked directly, addresses via multiply.
  task automatic model(input logic [7:0] b, output int exp_low);
    wr_t w;
    bit nl;
    nl = 1'b0;
    exp_low = 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      w.addr = (m_first + m_row * 80 + m_col) % 2048; w.data = int'(b);
      exp_wr.push_back(w);
      if (m_col < 79) m_col++;
      else begin m_col = 0; nl = 1'b1; end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) nl = 1'b1;
    else if (b == 8'h08) begin if (m_col > 0) m_col--; end
    else if (b == 8'h0C) begin
      m_row = 0; m_col = 0; m_first = 0;
      push_fill();
      exp_low = 0;
    end
    if (nl) begin
      if (m_row < 24) m_row++;
      else begin
        m_first = (m_first + 80) % 2048;
        exp_fc.push_back(m_first);
        for (int k = 0; k < 80; k++) begin
          w.addr = (m_first + 24 * 80 + k) % 2048; w.data = 32;
          exp_wr.push_back(w);
        end
        exp_low = 82;
      end
    end
  endtask

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) flag("ready_timeout", n);
  endtask

  task automatic send(input logic [7:0] b);
    int low, exp_low;
    wait_ready(5000);
    model(b, exp_low);
    char_in = b;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in = 8'h7F;
    low = 0;
    @(negedge clk);
    while (!char_ready && low < 5000) begin
      low++;
      @(negedge clk);
    end
    if (exp_low > 0) check("ready_low_cycles", low, exp_low);
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, "_row"}, 32'(cursor_row), row);
    check({name, "_col"}, 32'(cursor_col), col);
  endtask

  task automatic check_drained(input string name);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_fc_left"}, exp_fc.size(), 0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    char_valid = 1'b0;
    #1;
    check("rst_wen", 32'(buffer_wen), 0);
    check("rst_fcwen", 32'(buffer_first_char_wen), 0);
    check("rst_ready", 32'(char_ready), 0);
    check_cursor("rst_cursor", 0, 0);
    exp_wr.delete();
    exp_fc.delete();
    m_row = 0; m_col = 0; m_first = 0;
    push_fill();
    @(negedge clk);
    clr = 1'b0;
    wait_ready(5000);
    check("fill_ready", 32'(char_ready), 1);
    check_cursor("fill_cursor", 0, 0);
    check_drained("fill");
  endtask

  initial begin
    int exp_low;
    @(negedge clk);
    // Reset fill
    do_reset();

    // Printable writes 'A','B'
    send(8'h41);
    send(8'h42);
    check_cursor("ab_cursor", 0, 2);
    check_drained("ab");

    // CR/LF/BS sequence, BS at column 0, then 'Y' at address 80
    send(8'h58); send(8'h0D); send(8'h0A); send(8'h08);
    check_cursor("crlfbs_cursor", 1, 0);
    send(8'h59);
    check_cursor("y_cursor", 1, 1);
    check_drained("y");

    // Ignored control byte and BS mid-line
    send(8'h07);
    check_cursor("ignored_cursor", 1, 1);
    send(8'h08);
    check_cursor("bs_cursor", 1, 0);

    // Scroll: 25 LFs from reset
    do_reset();
    for (int i = 0; i < 25; i++) send(8'h0A);
    check_cursor("scroll_cursor", 24, 0);
    check("scroll_fc", last_fc, 80);
    check_drained("scroll");

    // Printable at column 79 of the bottom row triggers a scroll
    for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26));
    check_cursor("wrap_cursor", 24, 0);
    check("wrap_fc", last_fc, 160);
    check_drained("wrapline");

    // Pointer wrap: 26 scrolls from reset
    do_reset();
    for (int i = 0; i < 50; i++) send(8'h0A);
    check("ptr_wrap_fc", last_fc, 32);
    check_cursor("ptr_wrap_cursor", 24, 0);
    check_drained("ptr_wrap");

    // Form feed from (10,5)
    for (int i = 0; i < 14; i++) send(8'h0A);
    send(8'h0D);
    for (int i = 0; i < 10; i++) send(8'h0A);
    check_cursor("pre_ff_cursor", 24, 0);
    do_reset();
    for (int i = 0; i < 10; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h63);
    check_cursor("pre_ff2_cursor", 10, 5);
    send(8'h0C);
    wait_ready(5000);
    check_cursor("ff_cursor", 0, 0);
    check("ff_fc", last_fc, 0);
    check_drained("ff");

    // clr asserted during CLEAR
    for (int i = 0; i < 24; i++) send(8'h0A);
    wait_ready(5000);
    model(8'h0A, exp_low);
    char_in = 8'h0A;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("midclr_wen_before", 32'(buffer_wen), 1);
    #2;
    do_reset();
    send(8'h5A);
    check_cursor("after_midclr_cursor", 0, 1);
    check_drained("after_midclr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
